// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable clock divider with run/halt control.
//
// Divides the board clock by a loadable divisor N (>= 2). The phase counter
// runs 0..N-1; clk_out is low for floor(N/2) cycles and high for the rest of
// the period, and is driven straight from a flop. A one-cycle tick marks the
// first high cycle. New divisors are staged in a pending register and only
// take effect at a period boundary, so clk_out never shows a runt pulse.
// Dropping run lets the current period finish before the divider halts.
//
// Optional build macro:
//   CLKDIV_STEP_EN - adds a STEP state: a step pulse while halted produces
//                    exactly one clk_out period, then the divider halts again.
//                    Without it the step port is accepted but ignored.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             step,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             pending,
  output logic             halted
);

  // Divisor in effect after reset; anything below 2 would stall the counter.
  localparam logic [CNT_W-1:0] DIV_RST =
    (DIV_DEFAULT < 2) ? CNT_W'(2) : CNT_W'(DIV_DEFAULT);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pend_div;

  logic             counting;
  logic             at_last;
  logic             wrap;
  logic             apply_pend;

  // Divisors 0 and 1 are meaningless for a two-phase clock; force them to 2.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  // Length of the low phase for divisor n: floor(n/2).
  function automatic logic [CNT_W-1:0] low_len(input logic [CNT_W-1:0] n);
    return n >> 1;
  endfunction

`ifndef CLKDIV_STEP_EN
  // The step strobe has no function in this build.
  logic unused_step;
  assign unused_step = step;
`endif

  // Phase decode shared by the FSM and the counter.
  always_comb begin
    half    = low_len(div_active);
    at_last = (cnt == (div_active - CNT_W'(1)));
    wrap    = counting && at_last;
    // HALT has no period in flight, so a pending divisor can go in at once.
    apply_pend = pending && (halted || wrap);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_HALT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; every exit to HALT lands on a period boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HALT: begin
        if (run) begin
          state_nxt = ST_RUN;
`ifdef CLKDIV_STEP_EN
        end else if (step) begin
          state_nxt = ST_STEP;
`endif
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_nxt = at_last ? ST_HALT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // run is deliberately ignored here: the period always completes.
        if (at_last) begin
          state_nxt = ST_HALT;
        end
      end
`ifdef CLKDIV_STEP_EN
      ST_STEP: begin
        // Further step pulses are ignored until the single period is done.
        if (at_last) begin
          state_nxt = ST_HALT;
        end
      end
`endif
      default: state_nxt = ST_HALT;
    endcase
  end

  // FSM outputs: halted flag and the counter enable.
  always_comb begin
    halted   = (state == ST_HALT);
    counting = (state != ST_HALT);
  end

  // Next phase: advance and wrap while counting, hold at zero when halted.
  always_comb begin
    if (counting) begin
      cnt_nxt = at_last ? '0 : (cnt + CNT_W'(1));
    end else begin
      cnt_nxt = '0;
    end
  end

  // Phase counter and registered clock/tick, both derived from the next phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      // At a wrap cnt_nxt is 0, so the old divisor's half is still correct.
      clk_out <= (cnt_nxt >= half);
      tick    <= (cnt_nxt == half);
    end
  end

  // Active divisor and pending flag; a load on a boundary waits for the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_active <= DIV_RST;
      pending    <= 1'b0;
    end else begin
      if (apply_pend) begin
        div_active <= pend_div;
      end
      if (div_load) begin
        pending <= 1'b1;
      end else if (apply_pend) begin
        pending <= 1'b0;
      end
    end
  end

  // Pending divisor value; only meaningful while pending is set.
  always_ff @(posedge clk) begin
    if (div_load) begin
      pend_div <= clamp_div(div_in);
    end
  end

endmodule
